// File: rtl/mips_debug_console.sv
// mips_debug_console: board-level debug console for the MIPS SoC.
// Generates a one-cycle processor clock-enable from a debounced step button
// or a free-running rate, counts strobes, and scans a selectable 32-bit
// probe onto a multiplexed active-low seven-segment display.
module mips_debug_console #(
    parameter int NUM_CH  = 16,
    parameter int DIGITS  = 4,
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 5000,
    parameter int DB_MS   = 10,
    parameter int RUN_HZ  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      button,
    input  logic                      run_mode,
    input  logic                      freeze,
    input  logic                      half,
    input  logic [$clog2(NUM_CH)-1:0] sel,
    input  logic [NUM_CH*32-1:0]      probes,
    output logic                      cpu_en,
    output logic [15:0]               step_count,
    output logic [DIGITS-1:0]         LEDSEL,
    output logic [7:0]                LEDOUT
);
    localparam int SEL_W    = $clog2(NUM_CH);
    localparam int TICK_DIV = (CLK_HZ / SCAN_HZ < 1) ? 1 : CLK_HZ / SCAN_HZ;
    localparam int RUN_DIV  = (CLK_HZ / RUN_HZ < 1) ? 1 : CLK_HZ / RUN_HZ;
    localparam int DB_RAW   = DB_MS * SCAN_HZ / 1000;
    localparam int DB_TICKS = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int TICK_W   = $clog2(TICK_DIV + 1);
    localparam int RUN_W    = $clog2(RUN_DIV + 1);
    localparam int DB_W     = $clog2(DB_TICKS + 1);
    localparam int IDX_W    = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] DIG_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_ARM     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_PRESSED = 3'd3,
        ST_WAIT_LO = 3'd4
    } db_state_t;

    // Active-low hex glyph {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_glyph = 7'h40;
            4'h1:    hex_glyph = 7'h79;
            4'h2:    hex_glyph = 7'h24;
            4'h3:    hex_glyph = 7'h30;
            4'h4:    hex_glyph = 7'h19;
            4'h5:    hex_glyph = 7'h12;
            4'h6:    hex_glyph = 7'h02;
            4'h7:    hex_glyph = 7'h78;
            4'h8:    hex_glyph = 7'h00;
            4'h9:    hex_glyph = 7'h10;
            4'hA:    hex_glyph = 7'h08;
            4'hB:    hex_glyph = 7'h03;
            4'hC:    hex_glyph = 7'h46;
            4'hD:    hex_glyph = 7'h21;
            4'hE:    hex_glyph = 7'h06;
            4'hF:    hex_glyph = 7'h0E;
            default: hex_glyph = 7'h7F;
        endcase
    endfunction

    logic [3:0]        in_meta_r, in_sync_r;
    logic [SEL_W-1:0]  sel_meta_r, sel_sync_r;
    logic              btn_s, run_s, frz_s, half_s;
    logic [TICK_W-1:0] presc_r;
    logic              tick_s;
    db_state_t         state_r, state_nxt_s;
    logic [DB_W-1:0]   db_cnt_r, db_cnt_nxt_s;
    logic              step_req_s;
    logic              run_prev_r, run_edge_s, run_tick_s;
    logic [RUN_W-1:0]  run_cnt_r;
    logic              en_nxt_s, cpu_en_r;
    logic [15:0]       step_count_r;
    logic [31:0]       probe_s, disp_r, disp_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    int                nib_base_s;
    logic [3:0]        nib_s;
    logic              dp_low_s;
    logic [DIGITS-1:0] ledsel_r;
    logic [7:0]        ledout_r;

    assign {btn_s, run_s, frz_s, half_s} = in_sync_r;

    // Two-flop synchronisers for every asynchronous board input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_meta_r  <= 4'b0000;
            in_sync_r  <= 4'b0000;
            sel_meta_r <= '0;
            sel_sync_r <= '0;
        end else begin
            in_meta_r  <= {button, run_mode, freeze, half};
            in_sync_r  <= in_meta_r;
            sel_meta_r <= sel;
            sel_sync_r <= sel_meta_r;
        end
    end

    assign tick_s = (presc_r == TICK_W'(TICK_DIV - 1));

    // Scan/debounce prescaler, one-cycle tick at terminal count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + TICK_W'(1);
        end
    end

    // Debounce/step FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_ARM;
            db_cnt_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            db_cnt_r <= db_cnt_nxt_s;
        end
    end

    // Debounce/step FSM next state; step_req fires on entry to PRESSED
    always_comb begin
        state_nxt_s  = state_r;
        db_cnt_nxt_s = db_cnt_r;
        step_req_s   = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_ARM: begin
                    if (btn_s) begin
                        db_cnt_nxt_s = '0;
                    end else if (db_cnt_r == DB_W'(DB_TICKS - 1)) begin
                        state_nxt_s  = ST_IDLE;
                        db_cnt_nxt_s = '0;
                    end else begin
                        db_cnt_nxt_s = db_cnt_r + DB_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (btn_s) begin
                        state_nxt_s  = ST_WAIT_HI;
                        db_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end
                ST_WAIT_HI: begin
                    if (!btn_s) begin
                        state_nxt_s  = ST_IDLE;
                        db_cnt_nxt_s = '0;
                    end else if (db_cnt_r == DB_W'(DB_TICKS - 1)) begin
                        state_nxt_s  = ST_PRESSED;
                        db_cnt_nxt_s = '0;
                        step_req_s   = 1'b1;
                    end else begin
                        db_cnt_nxt_s = db_cnt_r + DB_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!btn_s) begin
                        state_nxt_s  = ST_WAIT_LO;
                        db_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s  = ST_PRESSED;
                    end
                end
                ST_WAIT_LO: begin
                    if (btn_s) begin
                        state_nxt_s  = ST_PRESSED;
                        db_cnt_nxt_s = '0;
                    end else if (db_cnt_r == DB_W'(DB_TICKS - 1)) begin
                        state_nxt_s  = ST_IDLE;
                        db_cnt_nxt_s = '0;
                    end else begin
                        db_cnt_nxt_s = db_cnt_r + DB_W'(1);
                    end
                end
                default: begin
                    state_nxt_s  = ST_ARM;
                    db_cnt_nxt_s = '0;
                end
            endcase
        end else begin
            state_nxt_s  = state_r;
            db_cnt_nxt_s = db_cnt_r;
        end
    end

    assign run_edge_s = run_s ^ run_prev_r;
    assign run_tick_s = run_s && !run_edge_s && (run_cnt_r == RUN_W'(RUN_DIV - 1));

    // Run-rate counter, held clear when stopped and restarted on any mode edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_prev_r <= 1'b0;
            run_cnt_r  <= '0;
        end else begin
            run_prev_r <= run_s;
            if (!run_s || run_edge_s || run_tick_s) begin
                run_cnt_r <= '0;
            end else begin
                run_cnt_r <= run_cnt_r + RUN_W'(1);
            end
        end
    end

    // Back-to-back strobes are suppressed so a mode switch cannot stretch cpu_en
    assign en_nxt_s = (run_s ? run_tick_s : step_req_s) && !cpu_en_r;

    // Registered clock-enable strobe and its wrapping counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_en_r     <= 1'b0;
            step_count_r <= 16'h0000;
        end else begin
            cpu_en_r <= en_nxt_s;
            if (en_nxt_s) begin
                step_count_r <= step_count_r + 16'h0001;
            end
        end
    end

    // Probe channel mux; out-of-range selects fall back to channel 0
    always_comb begin
        probe_s = probes[31:0];
        if (int'(sel_sync_r) < NUM_CH) begin
            probe_s = probes[32*int'(sel_sync_r) +: 32];
        end else begin
            probe_s = probes[31:0];
        end
    end

    // Display value about to be latched; the scan uses it on the same tick
    always_comb begin
        disp_nxt_s = disp_r;
        if (tick_s && !frz_s) begin
            disp_nxt_s = probe_s;
        end else begin
            disp_nxt_s = disp_r;
        end
    end

    // Nibble and decimal point for the digit being scanned out
    always_comb begin
        nib_base_s = 4 * int'(idx_r);
        if (DIGITS == 4 && half_s) begin
            nib_base_s = nib_base_s + 16;
        end else begin
            nib_base_s = 4 * int'(idx_r);
        end
        nib_s    = disp_nxt_s[nib_base_s +: 4];
        dp_low_s = ((idx_r == '0) && frz_s) ||
                   ((idx_r == IDX_W'(DIGITS - 1)) && run_s);
    end

    // Display register and digit scan; outputs stay dark until the first tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_r   <= 32'h0000_0000;
            idx_r    <= '0;
            ledsel_r <= '1;
            ledout_r <= 8'hFF;
        end else begin
            disp_r <= disp_nxt_s;
            if (tick_s) begin
                ledsel_r <= ~(DIG_ONE << idx_r);
                ledout_r <= {~dp_low_s, hex_glyph(nib_s)};
                if (idx_r == IDX_W'(DIGITS - 1)) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end
        end
    end

    assign cpu_en     = cpu_en_r;
    assign step_count = step_count_r;
    assign LEDSEL     = ledsel_r;
    assign LEDOUT     = ledout_r;

endmodule

// File: tb/tb_mips_debug_console.sv
// Scoreboard bench for mips_debug_console: stimulus pushes expected strobe
// counts and display frames; two monitors pop and compare them.
module tb_mips_debug_console;
    localparam int NUM_CH  = 5;
    localparam int DIGITS  = 4;
    localparam int CLK_HZ  = 1000;
    localparam int SCAN_HZ = 100;
    localparam int DB_MS   = 30;
    localparam int RUN_HZ  = 50;
    localparam int TICK    = 10;
    localparam int RUN_P   = 20;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 button = 1'b0;
    logic                 run_mode = 1'b0;
    logic                 freeze = 1'b0;
    logic                 half = 1'b0;
    logic [2:0]           sel = 3'd2;
    logic [NUM_CH*32-1:0] probes;
    logic                 cpu_en;
    logic [15:0]          step_count;
    logic [DIGITS-1:0]    LEDSEL;
    logic [7:0]           LEDOUT;

    logic [31:0] ch [NUM_CH];
    logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [31:0] val;
        bit          hw;
        bit          frz;
        bit          run;
    } frame_t;

    frame_t      disp_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] model_cnt = 16'h0000;
    int          frames_done = 0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_pulse = -1;
    bit          in_run = 1'b0;

    mips_debug_console #(
        .NUM_CH(NUM_CH), .DIGITS(DIGITS), .CLK_HZ(CLK_HZ),
        .SCAN_HZ(SCAN_HZ), .DB_MS(DB_MS), .RUN_HZ(RUN_HZ)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .run_mode(run_mode),
        .freeze(freeze), .half(half), .sel(sel), .probes(probes),
        .cpu_en(cpu_en), .step_count(step_count), .LEDSEL(LEDSEL), .LEDOUT(LEDOUT)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) probes[k*32 +: 32] = ch[k];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe monitor: every cpu_en must match a queued expectation
    initial begin : strobe_mon
        logic        prev;
        logic [15:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && cpu_en) begin
                check("cpu_en_width", 32'(prev), 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL cpu_en_unexpected: strobe at cycle %0d, step_count %0d, none expected", cyc, step_count);
                end else begin
                    e = exp_q.pop_front();
                    check("step_count", 32'(step_count), 32'(e));
                end
                if (in_run && last_pulse >= 0) check("run_gap", 32'(cyc - last_pulse), 32'(RUN_P));
                if (in_run) last_pulse = cyc;
            end
            prev = rst ? cpu_en : 1'b0;
        end
    end

    // Display monitor: one queued frame is checked over a full scan of DIGITS
    initial begin : disp_mon
        frame_t            f;
        logic [DIGITS-1:0] ls_prev;
        int                t, zeros, d;
        logic [3:0]        nib;
        bit                dp;
        forever begin
            @(negedge clk);
            if (disp_q.size() > 0) begin
                f = disp_q.pop_front();
                for (int n = 0; n < DIGITS; n++) begin
                    ls_prev = LEDSEL;
                    t = 0;
                    do begin
                        @(negedge clk);
                        t++;
                    end while (LEDSEL == ls_prev && t < 3*TICK);
                    if (LEDSEL == ls_prev) begin
                        tests++;
                        fails++;
                        $display("FAIL scan_timeout: LEDSEL stuck at %b", LEDSEL);
                    end else begin
                        zeros = 0;
                        d = 0;
                        for (int k = 0; k < DIGITS; k++) begin
                            if (!LEDSEL[k]) begin
                                zeros++;
                                d = k;
                            end
                        end
                        check("ledsel_onehot", 32'(zeros), 32'd1);
                        nib = f.hw ? f.val[16 + 4*d +: 4] : f.val[4*d +: 4];
                        dp  = (d == 0 && f.frz) || (d == DIGITS-1 && f.run);
                        check("ledout_digit", 32'(LEDOUT), 32'({~dp, glyph[nib]}));
                    end
                end
                frames_done++;
            end
        end
    end

    task automatic show(input logic [31:0] v, input bit h, input bit fz, input bit rn);
        frame_t f;
        int     target;
        int     t;
        f.val = v; f.hw = h; f.frz = fz; f.run = rn;
        target = frames_done + 1;
        t = 0;
        disp_q.push_back(f);
        while (frames_done < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("frame_done", 32'(frames_done >= target), 32'd1);
    endtask

    task automatic expect_drained(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic press_long(input int hold);
        model_cnt = model_cnt + 16'd1;
        exp_q.push_back(model_cnt);
        button = 1'b1;
        wait_cycles(hold);
        button = 1'b0;
        wait_cycles(60);
    endtask

    task automatic run_phase(input int n, input bit with_press, input bit with_frame);
        for (int i = 0; i < n; i++) begin
            model_cnt = model_cnt + 16'd1;
            exp_q.push_back(model_cnt);
        end
        last_pulse = -1;
        in_run = 1'b1;
        run_mode = 1'b1;
        fork
            wait_cycles(n*RUN_P + 5);
            begin
                if (with_press) begin
                    wait_cycles(15);
                    button = 1'b1;
                    wait_cycles(60);
                    button = 1'b0;
                end
            end
            begin
                if (with_frame) begin
                    wait_cycles(30);
                    show(ch[2], half, 1'b0, 1'b1);
                end
            end
        join
        run_mode = 1'b0;
        wait_cycles(5);
        in_run = 1'b0;
        expect_drained("run_pulses");
        wait_cycles(60);
    endtask

    // Global watchdog
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence
    initial begin : stim
        int          s;
        logic [31:0] v;
        bit          h;
        for (int k = 0; k < NUM_CH; k++) ch[k] = $urandom;
        ch[2] = 32'h1234_5678;

        // reset state
        wait_cycles(3);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_step_count", 32'(step_count), 32'd0);
        check("rst_ledsel", 32'(LEDSEL), 32'hF);
        check("rst_ledout", 32'(LEDOUT), 32'hFF);
        rst = 1'b1;
        wait_cycles(3);
        check("pre_tick_ledsel", 32'(LEDSEL), 32'hF);
        check("pre_tick_ledout", 32'(LEDOUT), 32'hFF);

        // clean presses
        wait_cycles(5*TICK);
        press_long(6*TICK);
        expect_drained("press1");
        check("press1_count", 32'(step_count), 32'd1);
        press_long(6*TICK);
        expect_drained("press2");
        check("press2_count", 32'(step_count), 32'd2);

        // display, lower and upper half, out-of-range select
        show(ch[2], 1'b0, 1'b0, 1'b0);
        half = 1'b1;
        wait_cycles(3*TICK);
        show(ch[2], 1'b1, 1'b0, 1'b0);
        half = 1'b0;
        sel = 3'd5;
        wait_cycles(3*TICK);
        show(ch[0], 1'b0, 1'b0, 1'b0);
        sel = 3'd2;
        wait_cycles(3*TICK);

        // freeze
        v = ch[2];
        freeze = 1'b1;
        wait_cycles(3*TICK);
        ch[2] = 32'hFFFF_FFFF;
        wait_cycles(3*TICK);
        show(v, 1'b0, 1'b1, 1'b0);
        freeze = 1'b0;
        wait_cycles(3*TICK);
        show(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // bounce then hold
        model_cnt = model_cnt + 16'd1;
        exp_q.push_back(model_cnt);
        for (int i = 0; i < 20; i++) begin
            button = ~button;
            wait_cycles(5);
        end
        button = 1'b1;
        wait_cycles(6*TICK);
        button = 1'b0;
        wait_cycles(60);
        expect_drained("bounce");

        // run mode with a press that must be ignored
        run_phase(10, 1'b1, 1'b1);

        // randomized presses/glitches and display selections
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                press_long(int'($urandom_range(60, 90)));
            end else begin
                button = 1'b1;
                wait_cycles(int'($urandom_range(1, 15)));
                button = 1'b0;
                wait_cycles(60);
            end
            expect_drained("rand_press");
            for (int k = 0; k < NUM_CH; k++) ch[k] = $urandom;
            s = int'($urandom_range(0, 7));
            h = 1'($urandom_range(0, 1));
            sel = 3'(s);
            half = h;
            wait_cycles(3*TICK);
            show((s < NUM_CH) ? ch[s] : ch[0], h, 1'b0, 1'b0);
        end
        sel = 3'd2;
        half = 1'b0;

        // reset in the middle of a press
        button = 1'b1;
        wait_cycles(25);
        rst = 1'b0;
        model_cnt = 16'h0000;
        wait_cycles(3);
        check("midrst_cpu_en", 32'(cpu_en), 32'd0);
        check("midrst_count", 32'(step_count), 32'(model_cnt));
        button = 1'b0;
        rst = 1'b1;
        wait_cycles(100);
        check("midrst_after", 32'(step_count), 32'(model_cnt));

        // button held through reset release
        button = 1'b1;
        rst = 1'b0;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(10*TICK);
        check("held_no_step", 32'(step_count), 32'd0);
        button = 1'b0;
        wait_cycles(5*TICK);
        press_long(6*TICK);
        expect_drained("held_then_press");
        check("held_count", 32'(step_count), 32'd1);

        // counter wrap
        model_cnt = 16'hFFFE;
        force dut.step_count_r = 16'hFFFE;
        @(negedge clk);
        release dut.step_count_r;
        run_phase(2, 1'b0, 1'b0);
        check("wrap_final", 32'(step_count), 32'(model_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
